// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: per-stage destination tag and
// the EX operand forward-select encoding.
package pipe_pkg;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Shadow tag kept for each of the E, M and W stages
  typedef struct packed {
    logic       reg_write;
    logic       is_load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } hz_tag_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam hz_tag_t HZ_BUBBLE = '0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward select for one EX operand: picks the youngest older writer of rs.
module hazard_fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       m_we,
  input  logic [4:0] m_rd,
  input  logic       w_we,
  input  logic [4:0] w_rd,
  output fwd_sel_t   sel
);

  // M is younger than W, so it wins; x0 is never a forward source
  always_comb begin
    sel = FWD_RF;
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))
      sel = FWD_M;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
      sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: load-use stall, branch flush, mem-wait freeze, EX forwarding
// and a sticky watchdog on long data-memory waits.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int         MAX_WAIT = 16,
  parameter logic [1:0] LOAD_SRC = RESULT_SRC_LOAD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rd_d,
  input  logic       reg_write_d,
  input  logic [1:0] result_src_d,
  input  logic       pc_src_e,
  input  logic       mem_ready_m,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       freeze,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       wait_timeout
);

  localparam int         NUM_OPS = 2;
  localparam logic [7:0] MAX_W8  = 8'(MAX_WAIT);

  hz_tag_t tag_d, tag_e, tag_m, tag_w;
  logic    mem_wait, load_use, flush_e_raw;
  logic [7:0] wait_cnt, wait_inc;

  logic [NUM_OPS-1:0][4:0] rs_e;
  fwd_sel_t [NUM_OPS-1:0]  fwd_sel;

  assign tag_d = '{reg_write: reg_write_d,
                   is_load:   (result_src_d == LOAD_SRC),
                   rd:        rd_d,
                   rs1:       rs1_d,
                   rs2:       rs2_d};

  assign mem_wait = ~mem_ready_m;
  assign load_use = tag_e.is_load && tag_e.reg_write && (tag_e.rd != 5'd0) &&
                    ((tag_e.rd == rs1_d) || (tag_e.rd == rs2_d));
  // Memory wait wins: EX is frozen, so a pending redirect re-presents later
  assign flush_e_raw = (load_use || pc_src_e) && !mem_wait;

  // Outputs are forced quiet while reset is held
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    freeze      = 1'b0;
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    if (rst_n) begin
      stall_f     = load_use || mem_wait;
      stall_d     = load_use || mem_wait;
      flush_d     = pc_src_e && !mem_wait;
      flush_e     = flush_e_raw;
      freeze      = mem_wait;
      forward_a_e = fwd_sel[0];
      forward_b_e = fwd_sel[1];
    end
  end

  // Shadow tag shift register; holds entirely while memory stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_e <= HZ_BUBBLE;
      tag_m <= HZ_BUBBLE;
      tag_w <= HZ_BUBBLE;
    end else if (!mem_wait) begin
      tag_w <= tag_m;
      tag_m <= tag_e;
      tag_e <= flush_e_raw ? HZ_BUBBLE : tag_d;
    end
  end

  assign rs_e = {tag_e.rs2, tag_e.rs1};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_fwd
      hazard_fwd_sel u_fwd (
        .rs   (rs_e[gi]),
        .m_we (tag_m.reg_write),
        .m_rd (tag_m.rd),
        .w_we (tag_w.reg_write),
        .w_rd (tag_w.rd),
        .sel  (fwd_sel[gi])
      );
    end
  endgenerate

  // Saturating increment; wrap to 0 at 0xFF never matches a legal MAX_WAIT
  assign wait_inc = wait_cnt + 8'd1;

  // Watchdog: count consecutive wait cycles, latch timeout until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= 8'd0;
      wait_timeout <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt != 8'hFF) wait_cnt <= wait_inc;
      if (wait_inc == MAX_W8) wait_timeout <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  // Tag fields that only matter in other stages
  logic unused_tag_bits;
  assign unused_tag_bits = ^{tag_m.is_load, tag_m.rs1, tag_m.rs2,
                             tag_w.is_load, tag_w.rs1, tag_w.rs2};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against an instruction-level
// reference model of the E/M/W pipe.
module tb_hazard_ctrl;
  localparam int MAX_WAIT = 16;

  logic       clk, rst_n;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       reg_write_d, pc_src_e, mem_ready_m;
  logic [1:0] result_src_d;
  logic       stall_f, stall_d, flush_d, flush_e, freeze, wait_timeout;
  logic [1:0] forward_a_e, forward_b_e;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .LOAD_SRC(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d),
    .pc_src_e(pc_src_e), .mem_ready_m(mem_ready_m),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .freeze(freeze), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .wait_timeout(wait_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: instructions occupying EX, MEM, WB
  typedef struct {
    bit we;
    bit ld;
    int rd;
    int rs1;
    int rs2;
  } ins_t;

  ins_t ex, mem, wb;
  int   wcnt;
  bit   to_exp;

  function automatic ins_t nop();
    ins_t n;
    n.we = 0; n.ld = 0; n.rd = 0; n.rs1 = 0; n.rs2 = 0;
    return n;
  endfunction

  function automatic void model_reset();
    ex = nop(); mem = nop(); wb = nop();
    wcnt = 0; to_exp = 0;
  endfunction

  // Youngest older instruction that writes src (x0 excluded) supplies it
  function automatic int fwd_of(int src);
    ins_t older[2];
    older[0] = mem;
    older[1] = wb;
    for (int i = 0; i < 2; i++)
      if (older[i].we && older[i].rd != 0 && older[i].rd == src)
        return (i == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit lu_now();
    return ex.ld && ex.we && ex.rd != 0 &&
           (ex.rd == int'(rs1_d) || ex.rd == int'(rs2_d));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model for the current inputs
  task automatic check_all(input string tag);
    bit mw, lu;
    mw = !mem_ready_m;
    lu = lu_now();
    chk({tag, ".stall_f"}, 8'(stall_f), 8'(lu || mw));
    chk({tag, ".stall_d"}, 8'(stall_d), 8'(lu || mw));
    chk({tag, ".flush_d"}, 8'(flush_d), 8'(pc_src_e && !mw));
    chk({tag, ".flush_e"}, 8'(flush_e), 8'((lu || pc_src_e) && !mw));
    chk({tag, ".freeze"},  8'(freeze),  8'(mw));
    chk({tag, ".fwd_a"},   8'(forward_a_e), 8'(fwd_of(ex.rs1)));
    chk({tag, ".fwd_b"},   8'(forward_b_e), 8'(fwd_of(ex.rs2)));
    chk({tag, ".timeout"}, 8'(wait_timeout), 8'(to_exp));
  endtask

  task automatic drive(input int r1, input int r2, input int rd, input bit we,
                       input int rsrc, input bit pc, input bit rdy);
    rs1_d = 5'(r1); rs2_d = 5'(r2); rd_d = 5'(rd);
    reg_write_d = we; result_src_d = 2'(rsrc);
    pc_src_e = pc; mem_ready_m = rdy;
    #1;
  endtask

  // Advance one clock and move the model the way the pipe moves
  task automatic tick();
    bit   mw, fe;
    ins_t dec;
    mw = !mem_ready_m;
    fe = (lu_now() || pc_src_e) && !mw;
    dec.we = reg_write_d; dec.ld = (result_src_d == 2'b01);
    dec.rd = rd_d; dec.rs1 = rs1_d; dec.rs2 = rs2_d;
    @(posedge clk);
    if (mw) begin
      wcnt++;
      if (wcnt >= MAX_WAIT) to_exp = 1;
    end else begin
      wcnt = 0;
      wb = mem; mem = ex;
      ex = fe ? nop() : dec;
    end
    #1;
  endtask

  task automatic step(input string tag, input int r1, input int r2, input int rd,
                      input bit we, input int rsrc, input bit pc, input bit rdy);
    drive(r1, r2, rd, we, rsrc, pc, rdy);
    check_all(tag);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    rs1_d = '0; rs2_d = '0; rd_d = '0; reg_write_d = 0; result_src_d = '0;
    pc_src_e = 1'b1; mem_ready_m = 1'b0;
    #2;
    // Reset must mask flush/freeze even with pc_src_e and mem_wait active
    chk("rst.stall_f", 8'(stall_f), 8'h0);
    chk("rst.flush_d", 8'(flush_d), 8'h0);
    chk("rst.freeze",  8'(freeze),  8'h0);
    chk("rst.timeout", 8'(wait_timeout), 8'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: lw x5 ; add x6,x5,x1 -> one bubble, then forward from W
    step("t1.lw", 0, 0, 5, 1, 1, 0, 1);
    drive(5, 1, 6, 1, 0, 0, 1);
    check_all("t1.use");
    chk("t1.stall_d", 8'(stall_d), 8'h1);
    chk("t1.flush_e", 8'(flush_e), 8'h1);
    tick();
    drive(5, 1, 6, 1, 0, 0, 1);
    check_all("t1.retry");
    chk("t1.no_stall", 8'(stall_f), 8'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    check_all("t1.ex");
    chk("t1.fwd_a_w", 8'(forward_a_e), 8'h1);
    tick();
    step("t1.drain", 0, 0, 0, 0, 0, 0, 1);

    // 2: add x5 ; sub x7,x5,x5 -> forward from M, then from W
    step("t2.add", 1, 2, 5, 1, 0, 0, 1);
    step("t2.sub", 5, 5, 7, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_all("t2.m");
    chk("t2.fwd_a_m", 8'(forward_a_e), 8'h2);
    chk("t2.fwd_b_m", 8'(forward_b_e), 8'h2);
    tick();
    step("t2.nop", 5, 5, 8, 1, 0, 0, 1);
    step("t2.w", 0, 0, 0, 0, 0, 0, 1);

    // 3: writer of x0 then reader of x0 -> no forward, no stall
    step("t3.wr0", 1, 1, 0, 1, 1, 0, 1);
    step("t3.rd0", 0, 0, 9, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    check_all("t3.ex");
    chk("t3.fwd_a", 8'(forward_a_e), 8'h0);
    tick();

    // 4: branch taken, then branch coinciding with load-use
    drive(0, 0, 0, 0, 0, 1, 1);
    check_all("t4.br");
    chk("t4.flush_d", 8'(flush_d), 8'h1);
    tick();
    step("t4.lw", 0, 0, 3, 1, 1, 0, 1);
    drive(3, 0, 4, 1, 0, 1, 1);
    check_all("t4.both");
    chk("t4.flush_e", 8'(flush_e), 8'h1);
    chk("t4.stall_d", 8'(stall_d), 8'h1);
    chk("t4.flush_d2", 8'(flush_d), 8'h1);
    tick();

    // 5: branch held across a 3-cycle memory wait
    step("t5.add", 0, 0, 10, 1, 0, 0, 1);
    step("t5.use", 10, 0, 11, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      check_all("t5.wait");
      chk("t5.fz_fwd", 8'(forward_a_e), 8'h2);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    check_all("t5.rel");
    chk("t5.flush_e", 8'(flush_e), 8'h1);
    tick();

    // 6: watchdog trips on the 16th wait edge and sticks
    for (int i = 0; i < MAX_WAIT; i++) step("t6.wait", 0, 0, 0, 0, 0, 0, 0);
    chk("t6.trip", 8'(wait_timeout), 8'h1);
    step("t6.ready", 0, 0, 0, 0, 0, 0, 1);
    chk("t6.sticky", 8'(wait_timeout), 8'h1);
    step("t6.w2", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("t6.rst_stall", 8'(stall_f), 8'h0);
    chk("t6.rst_freeze", 8'(freeze), 8'h0);
    chk("t6.rst_to", 8'(wait_timeout), 8'h0);
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    // Counter must restart from 0: 15 waits do not trip
    for (int i = 0; i < MAX_WAIT - 1; i++) step("t6.recount", 0, 0, 0, 0, 0, 0, 0);
    chk("t6.no_trip", 8'(wait_timeout), 8'h0);
    step("t6.clr", 0, 0, 0, 0, 0, 0, 1);

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      step("rnd",
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
